execute_md: RTL
===============

// Module: execute_md
// PURPOSE
//  Next-generation EX stage: operand forwarding, ALU, branch/jump target, plus an RV32M mul/div unit.
//  Mul/div runs multi-cycle under an FSM; md_busy_e stalls the pipeline until the result is ready.
//  Sits between the ID/EX register and the EX/MEM register; the hazard unit consumes md_busy_e.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width (even, >=8)
//  ADDRESS_WIDTH  32  PC width
//  MUL_LATENCY    2   cycles spent in MUL state (1..8)
// PORTS
//  clk            in   1    clock, rising edge
//  rst_n          in   1    asynchronous reset, active-low
//  flush_e        in   1    kill EX instruction incl. in-flight mul/div
//  valid_d        in   1    ID/EX holds a real instruction
//  md_op_d        in   1    instruction is RV32M
//  funct3_d       in   3    ALU funct3; mul/div op select when md_op_d
//  alu_control_d  in   4    ALU operation
//  alu_src_a_d    in   1    0: forwarded rs1, 1: pc_d
//  alu_src_b_d    in   1    0: forwarded rs2, 1: imm_val_d
//  adder_src_d    in   1    target base 0: pc_d, 1: forwarded rs1
//  jump_d         in   1    unconditional jump
//  branch_d       in   1    conditional branch
//  rd1_d, rd2_d   in   DW   register operands
//  pc_d           in   AW   instruction PC
//  imm_val_d      in   DW   immediate
//  alu_result_m   in   DW   MEM-stage forward value
//  result_w       in   DW   WB-stage forward value
//  forward_a_e    in   2    rs1 forward select
//  forward_b_e    in   2    rs2 forward select
//  alu_result_e   out  DW   ALU or mul/div result
//  write_data_e   out  DW   forwarded rs2 (store data)
//  pc_target_e    out  AW   base + imm_val_d
//  pc_src_e       out  1    redirect fetch
//  md_busy_e      out  1    stall request to hazard unit
//  md_done_e      out  1    mul/div result valid this cycle
// BEHAVIOUR
//  Forwarding: sel 00 -> rd*_d, 01 -> alu_result_m, 10 -> result_w, 11 -> rd*_d.
//  Non-md path is purely combinational (no latency), as before.
//  pc_src_e = ~md_op_d & (jump_d | branch_d & alu_result_e[0]). Target base uses the forwarded rs1.
//  Start cycle T: valid_d & md_op_d & state==IDLE & ~flush_e.
//    Latch forwarded operands and funct3. md_busy_e is combinationally 1 in T.
//  FSM states:
//    IDLE -> MUL (funct3[2]=0) or DIV (funct3[2]=1) on start.
//    MUL: MUL_LATENCY cycles, then DONE. Result = full 2*DW product of latched operands.
//      000 MUL low half; 001 MULH s*s, 010 MULHSU s*u, 011 MULHU u*u give the high half.
//    DIV: DW cycles of restoring radix-2 on magnitudes, sign fixup, then DONE.
//      100 DIV, 101 DIVU, 110 REM, 111 REMU.
//    Div special cases skip DIV and go IDLE -> DONE directly:
//      divisor==0: quotient all-ones, remainder = dividend.
//      signed MIN/-1: quotient = MIN, remainder = 0.
//    DONE: md_done_e=1, md_busy_e=0, alu_result_e = md result. Pipeline advances; next state IDLE.
//      No restart, because start requires IDLE.
//  md_busy_e = start | state in {MUL, DIV}.
//    While busy, alu_result_e = 0; ID/EX inputs are held stable by the stall.
//  Timing: MUL done at T+MUL_LATENCY+1; DIV done at T+DW+1; special-case DIV done at T+1.
//  flush_e: highest priority. Any state -> IDLE next edge, no md_done_e.
//    flush_e in cycle T suppresses start.
//  Reset (async, rst_n=0): state IDLE, counter 0, operand/result regs 0.
//    md_busy_e=0 and md_done_e=0 immediately. Other outputs follow their combinational inputs.
// TESTING
//  1. MUL 7 * 0xFFFFFFFD, MUL_LATENCY=2: busy T..T+2, done T+3, result 0xFFFFFFEB.
//  2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000;
//     MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  3. DIV 0xFFFFFFEC/3 -> 0xFFFFFFFA at T+33; REM same operands -> 0xFFFFFFFE; DIVU 100/7 -> 14.
//  4. DIVU 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
//     REM same -> 0.
//  5. ADD with forward_a_e=01, alu_result_m=0x10, alu_src_b_d=1, imm=4 -> 0x14 same cycle;
//     forward_a_e=11 uses rd1_d.
//  6. flush_e at T+5 of DIV -> IDLE at T+6, busy 0, no done;
//     rst_n low mid-MUL -> busy 0 at once, fresh MUL after release completes correctly.

Source files
------------

// File: rtl/execute_md.sv
// execute_md - EX stage with operand forwarding, ALU, branch/jump target and
// a multi-cycle RV32M multiply/divide unit.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush_e               kill EX instruction, including an in-flight mul/div
//   valid_d, md_op_d      ID/EX holds a real instruction / it is RV32M
//   funct3_d              ALU funct3, or mul/div op select when md_op_d
//   alu_control_d         ALU operation (see w_alu_res case for encoding)
//   alu_src_a_d/_b_d      ALU operand select (rs1/pc, rs2/imm)
//   adder_src_d           branch target base (pc / forwarded rs1)
//   jump_d, branch_d      control-flow type
//   rd1_d, rd2_d, pc_d,
//   imm_val_d             ID/EX operands
//   alu_result_m,
//   result_w              MEM / WB forward values
//   forward_a_e/_b_e      forward selects
//   alu_result_e          ALU or mul/div result
//   write_data_e          forwarded rs2 (store data)
//   pc_target_e           base + imm_val_d
//   pc_src_e              redirect fetch
//   md_busy_e             stall request to the hazard unit
//   md_done_e             mul/div result valid this cycle
module execute_md #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MUL_LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_e,
  input  logic                     valid_d,
  input  logic                     md_op_d,
  input  logic [2:0]               funct3_d,
  input  logic [3:0]               alu_control_d,
  input  logic                     alu_src_a_d,
  input  logic                     alu_src_b_d,
  input  logic                     adder_src_d,
  input  logic                     jump_d,
  input  logic                     branch_d,
  input  logic [DATA_WIDTH-1:0]    rd1_d,
  input  logic [DATA_WIDTH-1:0]    rd2_d,
  input  logic [ADDRESS_WIDTH-1:0] pc_d,
  input  logic [DATA_WIDTH-1:0]    imm_val_d,
  input  logic [DATA_WIDTH-1:0]    alu_result_m,
  input  logic [DATA_WIDTH-1:0]    result_w,
  input  logic [1:0]               forward_a_e,
  input  logic [1:0]               forward_b_e,
  output logic [DATA_WIDTH-1:0]    alu_result_e,
  output logic [DATA_WIDTH-1:0]    write_data_e,
  output logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     pc_src_e,
  output logic                     md_busy_e,
  output logic                     md_done_e
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] MIN_VAL  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] ONES_VAL = {DW{1'b1}};
  localparam logic [DW-1:0] ZERO_VAL = {DW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_op_a, r_op_b, r_quo, r_rem, r_dvs, r_result;
  logic [1:0]      r_f3;
  logic            r_neg_q, r_neg_r;

  logic [DW-1:0]   w_fwd_a, w_fwd_b, w_alu_a, w_alu_b, w_alu_res;
  logic [CW-1:0]   w_shamt;
  logic            w_start, w_div_signed, w_dbz, w_ovf, w_special;
  logic [DW-1:0]   w_special_res;
  logic [2*DW-1:0] w_a_ext, w_b_ext, w_prod;
  logic [DW-1:0]   w_mul_res;
  logic [DW:0]     w_rem_shift, w_diff;
  logic [DW-1:0]   w_quo_nxt, w_rem_nxt, w_div_res;

  // Magnitude of a value, taken only when it is a negative signed operand.
  function automatic logic [DW-1:0] mag(input logic is_signed, input logic [DW-1:0] x);
    if (is_signed && x[DW-1]) begin
      mag = -x;
    end else begin
      mag = x;
    end
  endfunction

  // Operand forwarding muxes for rs1 and rs2.
  always_comb begin
    w_fwd_a = rd1_d;
    w_fwd_b = rd2_d;
    case (forward_a_e)
      2'b01:   w_fwd_a = alu_result_m;
      2'b10:   w_fwd_a = result_w;
      default: w_fwd_a = rd1_d;
    endcase
    case (forward_b_e)
      2'b01:   w_fwd_b = alu_result_m;
      2'b10:   w_fwd_b = result_w;
      default: w_fwd_b = rd2_d;
    endcase
  end

  // Single-cycle ALU; compare ops return 1 in bit 0 when a branch is taken.
  always_comb begin
    w_alu_a = alu_src_a_d ? DW'(pc_d) : w_fwd_a;
    w_alu_b = alu_src_b_d ? imm_val_d : w_fwd_b;
    w_shamt = w_alu_b[CW-1:0];
    case (alu_control_d)
      4'd0:    w_alu_res = w_alu_a + w_alu_b;
      4'd1:    w_alu_res = w_alu_a - w_alu_b;
      4'd2:    w_alu_res = w_alu_a & w_alu_b;
      4'd3:    w_alu_res = w_alu_a | w_alu_b;
      4'd4:    w_alu_res = w_alu_a ^ w_alu_b;
      4'd5:    w_alu_res = {{(DW-1){1'b0}}, ($signed(w_alu_a) < $signed(w_alu_b))};
      4'd6:    w_alu_res = {{(DW-1){1'b0}}, (w_alu_a < w_alu_b)};
      4'd7:    w_alu_res = w_alu_a << w_shamt;
      4'd8:    w_alu_res = w_alu_a >> w_shamt;
      4'd9:    w_alu_res = DW'($signed(w_alu_a) >>> w_shamt);
      4'd10:   w_alu_res = w_alu_b;
      4'd11:   w_alu_res = {{(DW-1){1'b0}}, (w_alu_a == w_alu_b)};
      4'd12:   w_alu_res = {{(DW-1){1'b0}}, (w_alu_a != w_alu_b)};
      4'd13:   w_alu_res = {{(DW-1){1'b0}}, ($signed(w_alu_a) >= $signed(w_alu_b))};
      4'd14:   w_alu_res = {{(DW-1){1'b0}}, (w_alu_a >= w_alu_b)};
      default: w_alu_res = ZERO_VAL;
    endcase
  end

  // Start detection and divide special cases resolved in the start cycle.
  // rst_n gates start so busy drops the instant reset is asserted.
  always_comb begin
    w_start      = rst_n & valid_d & md_op_d & ~flush_e & (r_state == S_IDLE);
    w_div_signed = ~funct3_d[0];
    w_dbz        = (w_fwd_b == ZERO_VAL);
    w_ovf        = w_div_signed & (w_fwd_a == MIN_VAL) & (w_fwd_b == ONES_VAL);
    w_special    = funct3_d[2] & (w_dbz | w_ovf);
    if (w_dbz) begin
      w_special_res = funct3_d[1] ? w_fwd_a : ONES_VAL;
    end else begin
      w_special_res = funct3_d[1] ? ZERO_VAL : MIN_VAL;
    end
  end

  // Full-width product: sign-extend to 2*DW, the low 2*DW bits are exact.
  always_comb begin
    w_a_ext   = {{DW{((r_f3 == 2'b01) | (r_f3 == 2'b10)) & r_op_a[DW-1]}}, r_op_a};
    w_b_ext   = {{DW{(r_f3 == 2'b01) & r_op_b[DW-1]}}, r_op_b};
    w_prod    = w_a_ext * w_b_ext;
    w_mul_res = (r_f3 == 2'b00) ? w_prod[DW-1:0] : w_prod[2*DW-1:DW];
  end

  // One restoring-division step plus sign fixup of the step's outcome.
  always_comb begin
    w_rem_shift = {r_rem, r_quo[DW-1]};
    w_diff      = w_rem_shift - {1'b0, r_dvs};
    if (!w_diff[DW]) begin
      w_rem_nxt = w_diff[DW-1:0];
      w_quo_nxt = {r_quo[DW-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_rem_shift[DW-1:0];
      w_quo_nxt = {r_quo[DW-2:0], 1'b0};
    end
    if (r_f3[1]) begin
      w_div_res = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    end else begin
      w_div_res = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_e) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_start)         w_state_nxt = S_IDLE;
          else if (!funct3_d[2]) w_state_nxt = S_MUL;
          else if (w_special)    w_state_nxt = S_DONE;
          else                   w_state_nxt = S_DIV;
        end
        S_MUL:   w_state_nxt = (r_cnt == CW'(MUL_LATENCY - 1)) ? S_DONE : S_MUL;
        S_DIV:   w_state_nxt = (r_cnt == CW'(DW - 1)) ? S_DONE : S_DIV;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Mul/div datapath registers: operand latch, iteration and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= {CW{1'b0}};
      r_op_a   <= ZERO_VAL;
      r_op_b   <= ZERO_VAL;
      r_quo    <= ZERO_VAL;
      r_rem    <= ZERO_VAL;
      r_dvs    <= ZERO_VAL;
      r_result <= ZERO_VAL;
      r_f3     <= 2'b00;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= {CW{1'b0}};
      r_op_a  <= w_fwd_a;
      r_op_b  <= w_fwd_b;
      r_f3    <= funct3_d[1:0];
      r_quo   <= mag(w_div_signed, w_fwd_a);
      r_rem   <= ZERO_VAL;
      r_dvs   <= mag(w_div_signed, w_fwd_b);
      r_neg_q <= w_div_signed & (w_fwd_a[DW-1] ^ w_fwd_b[DW-1]);
      r_neg_r <= w_div_signed & w_fwd_a[DW-1];
      if (w_special) r_result <= w_special_res;
    end else if (!flush_e) begin
      case (r_state)
        S_MUL: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(MUL_LATENCY - 1)) r_result <= w_mul_res;
        end
        S_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          if (r_cnt == CW'(DW - 1)) r_result <= w_div_res;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Output muxing: md result in DONE, zero while stalled, ALU otherwise.
  always_comb begin
    md_busy_e    = w_start | (r_state == S_MUL) | (r_state == S_DIV);
    md_done_e    = (r_state == S_DONE) & ~flush_e;
    write_data_e = w_fwd_b;
    pc_target_e  = (adder_src_d ? AW'(w_fwd_a) : pc_d) + AW'(imm_val_d);
    if (r_state == S_DONE) begin
      alu_result_e = r_result;
    end else if (md_busy_e) begin
      alu_result_e = ZERO_VAL;
    end else begin
      alu_result_e = w_alu_res;
    end
    pc_src_e = ~md_op_d & (jump_d | (branch_d & alu_result_e[0]));
  end

endmodule
